sqrt_arbiter: RTL
=================

Name: sqrt_arbiter

Overview:
- Shares one `sqrt_int` instance (integer square root, WIDTH-bit radicand, ITER = WIDTH/2 iterations) among N requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- A round-robin scheduler grants one request at a time, drives the `start` pulse, waits for completion, and returns root/rem to the granted requester.
- Sits between the term-project processing blocks and the shared root unit.

Parameters:
- N, 4, number of requesters (≥2).
- WIDTH, 8, radicand width passed to `sqrt_int` (even, ≥4).
- TAG_W, $clog2(N), width of the requester index (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N  per-requester request valid.
- req_ready  out  N  per-requester request accept; at most one bit high.
- req_rad  in  N*WIDTH  radicands; requester k occupies bits [k*WIDTH +: WIDTH].
- rsp_valid  out  N  per-requester response valid; one-hot or zero.
- rsp_ready  in  N  per-requester response accept.
- rsp_root  out  WIDTH  root, shared bus, valid when any rsp_valid bit is high.
- rsp_rem  out  WIDTH  remainder, shared bus.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - Synchronous, active-high.
  - state=IDLE; rr pointer = N-1, so requester 0 has highest priority first.
  - req_ready=0, rsp_valid=0, rsp_root=0, rsp_rem=0, busy=0.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - If any req_valid is high, pick winner g = first set bit searching from ptr+1 upward, wrapping.
  - req_ready[g]=1 combinationally in the same cycle; all other bits 0.
  - On handshake: latch req_rad[g] into rad_q, latch g into tag, ptr←g, go to START.
- START:
  - Assert sqrt start=1 for exactly one cycle with rad=rad_q, then go to WAIT.
  - START exists so the unit's stale valid from the previous op is cleared before WAIT samples it.
- WAIT:
  - Stay while sqrt busy=1 or valid=0.
  - On valid=1 && busy=0: register root/rem into rsp_root/rsp_rem, go to RESP.
- RESP:
  - rsp_valid[tag]=1; rsp_root and rsp_rem are held stable.
  - On rsp_ready[tag]: go to IDLE and drop rsp_valid the next cycle.
  - rsp_ready bits of non-tag requesters are ignored.
- Latency, with handshake in cycle T:
  - start is high in T+1.
  - rsp_valid is first high in T+ITER+3; for WIDTH=8 that is T+7.
- Throughput: one operation per ITER+4 cycles at best, assuming zero response stall.
- No new request is accepted in START, WAIT or RESP; req_ready is all 0 there.
- A requester may deassert req_valid without a handshake; it is not latched.
- Fairness: the granted requester becomes lowest priority for the next arbitration, so no requester waits more than N-1 grants.
- Width rules:
  - rsp_root uses only bits [WIDTH/2-1:0]; the upper bits are 0 from the unit.
  - rsp_rem ≤ 2*root.
- Reset mid-operation (START/WAIT/RESP):
  - Abort to IDLE; the pending response is discarded and no rsp_valid is emitted.
  - `sqrt_int` has no reset and may still be busy. The next START's start pulse restarts it (start has priority in the unit), so the result is correct.
- Simultaneous rst and req_valid: reset wins; no handshake occurs.
- rsp_ready high while rsp_valid is 0: ignored.

Decomposition:
- Package `sqrt_arb_pkg` holds:
  - state_t enum {IDLE, START, WAIT, RESP}.
  - localparam helpers for ITER and TAG_W.
- Sub-module `rr_pick #(N)`: combinational round-robin picker with inputs req[N] and ptr, outputs grant_onehot[N], grant_idx and any.
- `sqrt_int #(WIDTH)` is instantiated unmodified.

Test Plan:
- Single request, requester 2, rad=200 → req_ready[2] same cycle; start at T+1; rsp_valid[2] at T+7; root=14, rem=4.
- Edge values on requester 0: rad=0 → 0/0; rad=255 → 15/30; rad=1 → 1/0; rad=64 → 8/0.
- All four requesters valid from reset, with distinct rads 9, 10, 99, 250 → grant order 0,1,2,3, roots 3,3,9,15, rems 0,1,18,25. Next round starts at 0.
- Round-robin rotation: after requester 1 is served, requesters 0 and 3 request together → 3 is granted first, then 0.
- Backpressure: rsp_ready[tag]=0 for 5 cycles → rsp_valid and root/rem stable; req_ready all 0; other requesters wait; release → IDLE next cycle.
- Reset pulsed in WAIT (cycle T+4) → no rsp_valid, busy=0 next cycle. A new request rad=144 is then served correctly: root=12, rem=0, at T'+7.

Source files
------------

// File: rtl/sqrt_arb_pkg.sv
// Shared types and sizing helpers for the square-root arbiter.
//   state_t  : arbiter FSM states
//   iter_of  : iteration count of sqrt_int for a given radicand width
//   tag_w_of : width of a requester index for a given requester count
package sqrt_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StResp
  } state_t;

  function automatic int unsigned iter_of(input int unsigned width);
    return width / 2;
  endfunction

  // Never narrower than one bit so a degenerate N still yields a legal vector.
  function automatic int unsigned tag_w_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req          : request vector
//   ptr          : last granted index; search starts at ptr+1 and wraps
//   grant_onehot : one-hot grant (zero when no request)
//   grant_idx    : index of the granted request
//   any          : at least one request present
module rr_pick
  import sqrt_arb_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned TAG_W = tag_w_of(N)
) (
  input  logic [N-1:0]     req,
  input  logic [TAG_W-1:0] ptr,
  output logic [N-1:0]     grant_onehot,
  output logic [TAG_W-1:0] grant_idx,
  output logic             any
);

  localparam int NI = int'(N);

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    // i runs 1..N so ptr itself is visited last.
    for (int i = 1; i <= NI; i++) begin
      if (!any && req[(int'(ptr) + i) % NI]) begin
        any                                   = 1'b1;
        grant_idx                             = TAG_W'((int'(ptr) + i) % NI);
        grant_onehot[(int'(ptr) + i) % NI]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sqrt_int.sv
// Iterative integer square root, two radicand bits retired per cycle.
//   clk   : clock
//   start : load rad and begin; has priority over an operation in flight
//   rad   : radicand
//   busy  : iterating
//   valid : root/rem hold the result of the last completed operation
//   root  : floor(sqrt(rad)), upper WIDTH/2 bits are zero
//   rem   : rad - root*root
// No reset: start fully initialises the datapath.
module sqrt_int #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             start,
  input  logic [WIDTH-1:0] rad,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] root,
  output logic [WIDTH-1:0] rem
);

  localparam int unsigned Half = WIDTH / 2;
  localparam int unsigned Iter = WIDTH / 2;
  // Partial remainder is at most 2*root (Half+1 bits); after shifting in two
  // radicand bits it needs Half+3.
  localparam int unsigned AccW = Half + 3;
  localparam int unsigned CntW = $clog2(Iter + 1);

  logic [WIDTH-1:0] x_q;
  logic [AccW-1:0]  acc_q;
  logic [Half-1:0]  root_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;
  logic             valid_q;

  logic [AccW-1:0] acc_sh;
  logic [AccW-1:0] trial;
  logic            fits;

  always_comb begin
    acc_sh = {acc_q[AccW-3:0], x_q[WIDTH-1 -: 2]};
    trial  = {1'b0, root_q, 2'b01};
    fits   = (acc_sh >= trial);
  end

  always_ff @(posedge clk) begin
    if (start) begin
      x_q     <= rad;
      acc_q   <= '0;
      root_q  <= '0;
      cnt_q   <= CntW'(Iter);
      busy_q  <= 1'b1;
      valid_q <= 1'b0;
    end else if (busy_q) begin
      x_q    <= x_q << 2;
      acc_q  <= fits ? (acc_sh - trial) : acc_sh;
      root_q <= {root_q[Half-2:0], fits};
      cnt_q  <= cnt_q - 1'b1;
      if (cnt_q == CntW'(1)) begin
        busy_q  <= 1'b0;
        valid_q <= 1'b1;
      end
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign root  = WIDTH'(root_q);
  assign rem   = WIDTH'(acc_q[Half:0]);

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one sqrt_int among N requesters.
//   clk, rst  : clock, synchronous active-high reset
//   req_valid : per-requester request valid
//   req_ready : per-requester request accept (at most one bit high)
//   req_rad   : packed radicands, requester k at [k*WIDTH +: WIDTH]
//   rsp_valid : per-requester response valid (one-hot or zero)
//   rsp_ready : per-requester response accept
//   rsp_root  : root of the current response (shared bus)
//   rsp_rem   : remainder of the current response (shared bus)
//   busy      : an operation is in progress
module sqrt_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter  int unsigned N     = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned TAG_W = tag_w_of(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req_valid,
  output logic [N-1:0]       req_ready,
  input  logic [N*WIDTH-1:0] req_rad,
  output logic [N-1:0]       rsp_valid,
  input  logic [N-1:0]       rsp_ready,
  output logic [WIDTH-1:0]   rsp_root,
  output logic [WIDTH-1:0]   rsp_rem,
  output logic               busy
);

  state_t           state_q, state_d;
  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] rad_q, rad_d;
  logic [WIDTH-1:0] root_q, root_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [N-1:0]     pick_onehot;
  logic [TAG_W-1:0] pick_idx;
  logic             pick_any;

  logic             sq_start;
  logic             sq_busy;
  logic             sq_valid;
  logic [WIDTH-1:0] sq_root;
  logic [WIDTH-1:0] sq_rem;

  logic [WIDTH-1:0] rad_arr [N];

  for (genvar k = 0; k < int'(N); k++) begin : g_rad
    assign rad_arr[k] = req_rad[k*WIDTH +: WIDTH];
  end

  rr_pick #(
    .N (N)
  ) u_pick (
    .req          (req_valid),
    .ptr          (ptr_q),
    .grant_onehot (pick_onehot),
    .grant_idx    (pick_idx),
    .any          (pick_any)
  );

  sqrt_int #(
    .WIDTH (WIDTH)
  ) u_sqrt (
    .clk   (clk),
    .start (sq_start),
    .rad   (rad_q),
    .busy  (sq_busy),
    .valid (sq_valid),
    .root  (sq_root),
    .rem   (sq_rem)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    tag_d     = tag_q;
    rad_d     = rad_q;
    root_d    = root_q;
    rem_d     = rem_q;
    req_ready = '0;
    rsp_valid = '0;
    sq_start  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Ready is only raised for the winner, so pick_any implies a handshake.
        if (pick_any) begin
          req_ready = pick_onehot;
          rad_d     = rad_arr[pick_idx];
          tag_d     = pick_idx;
          ptr_d     = pick_idx;
          state_d   = StStart;
        end
      end
      StStart: begin
        // Separate cycle so the unit's valid from the previous op is cleared
        // before StWait looks at it.
        sq_start = 1'b1;
        state_d  = StWait;
      end
      StWait: begin
        if (sq_valid && !sq_busy) begin
          root_d  = sq_root;
          rem_d   = sq_rem;
          state_d = StResp;
        end
      end
      StResp: begin
        rsp_valid[tag_q] = 1'b1;
        if (rsp_ready[tag_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Reset wins over a coincident request or a pending response.
    if (rst) begin
      req_ready = '0;
      rsp_valid = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= TAG_W'(N - 1);
      tag_q   <= '0;
      rad_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tag_q   <= tag_d;
      rad_q   <= rad_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign rsp_root = root_q;
  assign rsp_rem  = rem_q;

endmodule
